// File: rtl/dm_load_ext_pkg.sv
// Shared MIPS definitions for the data-memory load/store paths.
// Opcode constants are used by the load extender here and by the store side
// for its byte-enable decode.
package mips_defs;

  typedef enum logic [5:0] {
    OP_LB  = 6'b100000,
    OP_LH  = 6'b100001,
    OP_LW  = 6'b100011,
    OP_LBU = 6'b100100,
    OP_LHU = 6'b100101,
    OP_SB  = 6'b101000,
    OP_SH  = 6'b101001,
    OP_SW  = 6'b101011
  } opcode_e;

  // True for any of the five load opcodes.
  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

endpackage

// File: rtl/dm_load_ext_load_extender.sv
// load_extender: purely combinational byte/half/word extraction with sign or
// zero extension. Little-endian: offset 0 selects bits 7:0.
// Ports:
//   word   - raw 32-bit memory word
//   off    - byte offset within the word
//   op     - instruction opcode (ir[31:26])
//   result - extended load result (0 for non-load opcodes)
module load_extender
  import mips_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [5:0]  op,
  output logic [31:0] result
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = off[1] ? word[31:16] : word[15:0];
    unique case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  always_comb begin
    result = '0;
    case (op)
      OP_LW:   result = word;
      OP_LH:   result = {{16{half[15]}}, half};
      OP_LHU:  result = {16'h0000, half};
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h000000, byte_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dm_load_ext.sv
// dm_load_ext: W-stage read-side companion of the data memory.
// Flags load address errors in M, registers the memory word across the M/W
// boundary, and extracts/extends the load result for writeback.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   stall       - hold M/W register contents
//   flush       - insert bubble into W (beats stall)
//   addr_m      - load byte address in M
//   ir_m        - instruction in M
//   dout_m      - raw word read from data memory
//   adel_m      - load in M has address error (combinational)
//   ir_w        - registered instruction in W
//   ld_valid_w  - W holds a legal load to write back
//   ld_data_w   - extended load result (0 when not valid)
module dm_load_ext
  import mips_defs::*;
#(
  parameter int unsigned DM_WORDS = 2048,
  parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] addr_m,
  input  logic [31:0] ir_m,
  input  logic [31:0] dout_m,
  output logic        adel_m,
  output logic [31:0] ir_w,
  output logic        ld_valid_w,
  output logic [31:0] ld_data_w
);

  // 33 bits so a full 4 GiB memory size still compares correctly.
  localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) * 33'd4;

  logic [5:0]  op_m;
  logic        load_m;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] rel_addr;

  logic [31:0] word_w;
  logic [1:0]  off_w;
  logic        valid_w;
  logic [31:0] ext_data;

  assign op_m   = ir_m[31:26];
  assign load_m = is_load(op_m);

  always_comb begin
    misaligned = 1'b0;
    case (op_m)
      OP_LW:         misaligned = (addr_m[1:0] != 2'b00);
      OP_LH, OP_LHU: misaligned = addr_m[0];
      default:       misaligned = 1'b0;
    endcase
  end

  always_comb begin
    rel_addr     = addr_m - DM_BASE;
    out_of_range = (addr_m < DM_BASE) || ({1'b0, rel_addr} >= DM_BYTES);
  end

  assign adel_m = load_m && (misaligned || out_of_range);

  // Reset and flush both clear to a bubble, so they share a branch.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ir_w    <= '0;
      word_w  <= '0;
      off_w   <= '0;
      valid_w <= 1'b0;
    end else if (!stall) begin
      ir_w    <= ir_m;
      word_w  <= dout_m;
      off_w   <= addr_m[1:0];
      valid_w <= load_m && !adel_m;
    end
  end

  load_extender u_load_extender (
    .word   (word_w),
    .off    (off_w),
    .op     (ir_w[31:26]),
    .result (ext_data)
  );

  assign ld_valid_w = valid_w;
  assign ld_data_w  = valid_w ? ext_data : '0;

endmodule

// File: tb/tb_dm_load_ext.sv
module tb_dm_load_ext;
  import mips_defs::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] addr_m;
  logic [31:0] ir_m;
  logic [31:0] dout_m;
  logic        adel_m;
  logic [31:0] ir_w;
  logic        ld_valid_w;
  logic [31:0] ld_data_w;

  int checks = 0;
  int errors = 0;

  localparam logic [25:0] IR_LO = 26'h0ABCDEF;

  dm_load_ext #(
    .DM_WORDS (2048),
    .DM_BASE  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .addr_m     (addr_m),
    .ir_m       (ir_m),
    .dout_m     (dout_m),
    .adel_m     (adel_m),
    .ir_w       (ir_w),
    .ld_valid_w (ld_valid_w),
    .ld_data_w  (ld_data_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] dout);
    ir_m   = {op, IR_LO};
    addr_m = addr;
    dout_m = dout;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(OP_LW, 32'h0, 32'h1234_5678);
    tick();
    checks++;
    if (ir_w !== 32'h0) begin errors++; $display("FAIL reset_ir_w got %h want %h", ir_w, 32'h0); end
    checks++;
    if (ld_valid_w !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ld_valid_w); end
    checks++;
    if (ld_data_w !== 32'h0) begin errors++; $display("FAIL reset_data got %h want %h", ld_data_w, 32'h0); end
    reset = 1'b0;
  endtask

  task automatic test_byte_half();
    logic [5:0]  ops [12];
    logic [31:0] adr [12];
    logic [31:0] exp [12];
    ops = '{OP_LB, OP_LBU, OP_LB, OP_LBU, OP_LB, OP_LBU, OP_LB, OP_LBU,
            OP_LH, OP_LHU, OP_LH, OP_LHU};
    adr = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h2, 32'h2, 32'h3, 32'h3,
            32'h2, 32'h2, 32'h0, 32'h0};
    exp = '{32'hFFFF_FFA1, 32'h0000_00A1, 32'hFFFF_FFF0, 32'h0000_00F0,
            32'h0000_0065, 32'h0000_0065, 32'hFFFF_FF87, 32'h0000_0087,
            32'hFFFF_8765, 32'h0000_8765, 32'hFFFF_F0A1, 32'h0000_F0A1};
    for (int unsigned i = 0; i < 12; i++) begin
      drive(ops[i], adr[i], 32'h8765_F0A1);
      #1;
      checks++;
      if (adel_m !== 1'b0) begin errors++; $display("FAIL ext_adel[%0d] got %b want 0", i, adel_m); end
      tick();
      checks++;
      if (ld_valid_w !== 1'b1) begin errors++; $display("FAIL ext_valid[%0d] got %b want 1", i, ld_valid_w); end
      checks++;
      if (ld_data_w !== exp[i]) begin errors++; $display("FAIL ext_data[%0d] got %h want %h", i, ld_data_w, exp[i]); end
    end
  endtask

  task automatic test_adel();
    logic [5:0]  ops [9];
    logic [31:0] adr [9];
    logic        ead [9];
    logic [31:0] exp [9];
    ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LW, OP_LBU, OP_LH, OP_LW, OP_LW};
    adr = '{32'h6, 32'h3, 32'h1, 32'h3, 32'h2000, 32'h2003, 32'h1FFE,
            32'hFFFF_FFFC, 32'h1FFC};
    ead = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FF87, 32'h0, 32'h0, 32'hFFFF_8765,
            32'h0, 32'h8765_F0A1};
    for (int unsigned i = 0; i < 9; i++) begin
      drive(ops[i], adr[i], 32'h8765_F0A1);
      #1;
      checks++;
      if (adel_m !== ead[i]) begin errors++; $display("FAIL adel[%0d] got %b want %b", i, adel_m, ead[i]); end
      tick();
      checks++;
      if (ld_valid_w !== !ead[i]) begin errors++; $display("FAIL adel_valid[%0d] got %b want %b", i, ld_valid_w, !ead[i]); end
      checks++;
      if (ld_data_w !== exp[i]) begin errors++; $display("FAIL adel_data[%0d] got %h want %h", i, ld_data_w, exp[i]); end
      checks++;
      if (ir_w !== {ops[i], IR_LO}) begin errors++; $display("FAIL adel_ir[%0d] got %h want %h", i, ir_w, {ops[i], IR_LO}); end
    end
  endtask

  task automatic test_stall_flush();
    drive(OP_LW, 32'h8, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (ld_data_w !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_cap got %h want %h", ld_data_w, 32'hDEAD_BEEF); end
    stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(OP_LB, 32'h1 + i, 32'h1122_3344 + i);
      tick();
      checks++;
      if (ir_w !== {OP_LW, IR_LO}) begin errors++; $display("FAIL stall_ir[%0d] got %h want %h", i, ir_w, {OP_LW, IR_LO}); end
      checks++;
      if (ld_data_w !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", i, ld_data_w, 32'hDEAD_BEEF); end
      checks++;
      if (ld_valid_w !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, ld_valid_w); end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (ir_w !== 32'h0) begin errors++; $display("FAIL flush_ir got %h want 0", ir_w); end
    checks++;
    if (ld_valid_w !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", ld_valid_w); end
    checks++;
    if (ld_data_w !== 32'h0) begin errors++; $display("FAIL flush_data got %h want 0", ld_data_w); end
    flush = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(OP_LW, 32'h10, 32'hCAFE_F00D);
    tick();
    checks++;
    if (ld_data_w !== 32'hCAFE_F00D) begin errors++; $display("FAIL midrst_cap got %h want %h", ld_data_w, 32'hCAFE_F00D); end
    reset = 1'b1;
    stall = 1'b1;
    tick();
    checks++;
    if (ir_w !== 32'h0) begin errors++; $display("FAIL midrst_ir got %h want 0", ir_w); end
    checks++;
    if (ld_valid_w !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", ld_valid_w); end
    checks++;
    if (ld_data_w !== 32'h0) begin errors++; $display("FAIL midrst_data got %h want 0", ld_data_w); end
    reset = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_nonload();
    drive(OP_SW, 32'h6, 32'h5555_AAAA);
    #1;
    checks++;
    if (adel_m !== 1'b0) begin errors++; $display("FAIL sw_adel got %b want 0", adel_m); end
    tick();
    checks++;
    if (ld_valid_w !== 1'b0) begin errors++; $display("FAIL sw_valid got %b want 0", ld_valid_w); end
    checks++;
    if (ld_data_w !== 32'h0) begin errors++; $display("FAIL sw_data got %h want 0", ld_data_w); end
    checks++;
    if (ir_w !== {OP_SW, IR_LO}) begin errors++; $display("FAIL sw_ir got %h want %h", ir_w, {OP_SW, IR_LO}); end
  endtask

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    addr_m = '0;
    ir_m   = '0;
    dout_m = '0;
    test_reset();
    test_byte_half();
    test_adel();
    test_stall_flush();
    test_reset_mid();
    test_nonload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
